// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the RV32M multiply/divide unit.
//   muldiv_op_e    : operation code, funct3 order
//   muldiv_state_e : control FSM states
//   is_div / is_signed_a / is_signed_b : per-operation decode helpers
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    function automatic logic is_div(input muldiv_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_signed_a(input muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Shared 2*WIDTH accumulator datapath: one shift-add multiply step or one
// restoring-divide step per enabled cycle, working on unsigned magnitudes.
//   load_i      : capture operands (acc = {0, a_mag}, addend/divisor = b_mag)
//   step_i      : advance the accumulator by one iteration
//   div_mode_i  : 1 = restoring divide step, 0 = shift-add multiply step
//   a_mag_i     : multiplier / dividend magnitude
//   b_mag_i     : multiplicand / divisor magnitude
//   acc_step_c  : accumulator value after the current step (combinational);
//                 multiply -> full product, divide -> {remainder, quotient}
module muldiv_iter_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 div_mode_i,
    input  logic [WIDTH-1:0]     a_mag_i,
    input  logic [WIDTH-1:0]     b_mag_i,
    output logic [2*WIDTH-1:0]   acc_step_c
);

    localparam int unsigned W2 = 2 * WIDTH;

    logic [W2-1:0]    acc_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   trial_c;

    // One iteration of either algorithm
    always_comb begin
        sum_c      = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, opnd_q};
        // Shifted partial remainder minus divisor; bit WIDTH set means borrow
        trial_c    = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
        acc_step_c = acc_q;
        if (div_mode_i) begin
            if (!trial_c[WIDTH]) begin
                acc_step_c = {trial_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step_c = {acc_q[W2-2:0], 1'b0};
            end
        end else begin
            if (acc_q[0]) begin
                acc_step_c = {sum_c, acc_q[WIDTH-1:1]};
            end else begin
                acc_step_c = {1'b0, acc_q[W2-1:1]};
            end
        end
    end

    // Accumulator and operand registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else if (load_i) begin
            acc_q  <= {{WIDTH{1'b0}}, a_mag_i};
            opnd_q <= b_mag_i;
        end else if (step_i) begin
            acc_q  <= acc_step_c;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready request and result
// handshakes, registered result and zero/negative flags, and flush.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies complete in a single
// cycle through a full-width multiplier; divides stay iterative.
//   clk_i, reset_n_i       : clock, async active-low reset
//   valid_i, ready_o       : request handshake (ready_o high only in IDLE)
//   op_i, a_i, b_i         : operation and operands
//   flush_i                : abort, overrides every other input
//   valid_o, ready_i       : result handshake
//   result_o, zero_flag_o, neg_flag_o : result and its flags
//   busy_o                 : iterating (CALC)
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_flag_o,
    output logic             neg_flag_o,
    output logic             busy_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned W2    = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    muldiv_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    muldiv_op_e       op_q, op_d;
    logic             a_neg_q, a_neg_d;
    logic             b_neg_q, b_neg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    muldiv_op_e       op_in_c;
    logic             a_neg_in_c, b_neg_in_c;
    logic [WIDTH-1:0] a_mag_c, b_mag_c;
    logic             direct_c;
    logic [WIDTH-1:0] direct_res_c;
    logic             core_load_c, core_step_c;
    logic [W2-1:0]    core_acc_c;
    logic [W2-1:0]    prod_fix_c;
    logic [WIDTH-1:0] quo_fix_c, rem_fix_c, calc_res_c;

    assign op_in_c = muldiv_op_e'(op_i);

    // Operand signs and magnitudes of the incoming request
    always_comb begin
        a_neg_in_c = is_signed_a(op_in_c) && a_i[WIDTH-1];
        b_neg_in_c = is_signed_b(op_in_c) && b_i[WIDTH-1];
        a_mag_c    = a_neg_in_c ? -a_i : a_i;
        b_mag_c    = b_neg_in_c ? -b_i : b_i;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [W2-1:0]    fast_prod_c;
    logic [WIDTH-1:0] fast_res_c;

    // Single-cycle multiply on magnitudes with the same sign fix as the iterative path
    always_comb begin
        fast_prod_c = W2'(a_mag_c) * W2'(b_mag_c);
        if (a_neg_in_c ^ b_neg_in_c) begin
            fast_prod_c = -fast_prod_c;
        end
        fast_res_c = (op_in_c == OP_MUL) ? fast_prod_c[WIDTH-1:0] : fast_prod_c[W2-1:WIDTH];
    end
`endif

    // Requests resolved without iterating
    always_comb begin
        direct_c     = 1'b0;
        direct_res_c = '0;
        if (is_div(op_in_c) && (b_i == '0)) begin
            direct_c     = 1'b1;
            direct_res_c = ((op_in_c == OP_DIV) || (op_in_c == OP_DIVU)) ? '1 : a_i;
        end else if (((op_in_c == OP_DIV) || (op_in_c == OP_REM)) &&
                     (a_i == MIN_VAL) && (b_i == '1)) begin
            direct_c     = 1'b1;
            direct_res_c = (op_in_c == OP_DIV) ? a_i : '0;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!is_div(op_in_c)) begin
            direct_c     = 1'b1;
            direct_res_c = fast_res_c;
        end
`endif
    end

    muldiv_iter_core #(
        .WIDTH      (WIDTH)
    ) u_core (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .load_i     (core_load_c),
        .step_i     (core_step_c),
        .div_mode_i (is_div(op_q)),
        .a_mag_i    (a_mag_c),
        .b_mag_i    (b_mag_c),
        .acc_step_c (core_acc_c)
    );

    // Sign fix applied to the final iteration's accumulator
    always_comb begin
        prod_fix_c = (a_neg_q ^ b_neg_q) ? -core_acc_c : core_acc_c;
        quo_fix_c  = (a_neg_q ^ b_neg_q) ? -core_acc_c[WIDTH-1:0] : core_acc_c[WIDTH-1:0];
        rem_fix_c  = a_neg_q ? -core_acc_c[W2-1:WIDTH] : core_acc_c[W2-1:WIDTH];
        unique case (op_q)
            OP_MUL:                       calc_res_c = prod_fix_c[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: calc_res_c = prod_fix_c[W2-1:WIDTH];
            OP_DIV, OP_DIVU:              calc_res_c = quo_fix_c;
            default:                      calc_res_c = rem_fix_c;
        endcase
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_neg_d     = a_neg_q;
        b_neg_d     = b_neg_q;
        result_d    = result_q;
        valid_d     = valid_q;
        core_load_c = 1'b0;
        core_step_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (valid_i && ready_q) begin
                    op_d    = op_in_c;
                    a_neg_d = a_neg_in_c;
                    b_neg_d = b_neg_in_c;
                    if (direct_c) begin
                        result_d = direct_res_c;
                        valid_d  = 1'b1;
                        state_d  = DONE;
                    end else begin
                        core_load_c = 1'b1;
                        cnt_d       = CNT_W'(WIDTH - 1);
                        state_d     = CALC;
                    end
                end
            end
            CALC: begin
                core_step_c = 1'b1;
                cnt_d       = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    result_d = calc_res_c;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush squashes everything, including a same-cycle request
        if (flush_i) begin
            state_d     = IDLE;
            valid_d     = 1'b0;
            core_load_c = 1'b0;
            core_step_c = 1'b0;
        end

        ready_d = (state_d == IDLE);
        busy_d  = (state_d == CALC);
        zero_d  = (result_d == '0);
        neg_d   = result_d[WIDTH-1];
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            zero_q   <= 1'b1;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

    assign ready_o     = ready_q;
    assign valid_o     = valid_q;
    assign busy_o      = busy_q;
    assign result_o    = result_q;
    assign zero_flag_o = zero_q;
    assign neg_flag_o  = neg_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH = 32).
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk_i     = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        valid_i   = 1'b0;
    logic        ready_o;
    logic [2:0]  op_i      = 3'd0;
    logic [31:0] a_i       = '0;
    logic [31:0] b_i       = '0;
    logic        flush_i   = 1'b0;
    logic        valid_o;
    logic        ready_i   = 1'b0;
    logic [31:0] result_o;
    logic        zero_flag_o;
    logic        neg_flag_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .op_i        (op_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .flush_i     (flush_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .result_o    (result_o),
        .zero_flag_o (zero_flag_o),
        .neg_flag_o  (neg_flag_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic wait_ready();
        int n = 0;
        while (ready_o !== 1'b1 && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
    endtask

    // Issue one request, report result, flags and the cycle valid_o rose (-1 on timeout)
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic zf, output logic nf,
                         output int lat);
        wait_ready();
        op_i = op; a_i = a; b_i = b; valid_i = 1'b1; ready_i = 1'b0;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat = 1;
        while (valid_o !== 1'b1 && lat < 100) begin
            @(posedge clk_i); #1;
            lat++;
        end
        if (valid_o !== 1'b1) lat = -1;
        res = result_o; zf = zero_flag_o; nf = neg_flag_o;
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        #12;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b0 ||
            result_o !== 32'h0 || zero_flag_o !== 1'b1 || neg_flag_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b busy=%b res=%h z=%b n=%b, required 1 0 0 0 1 0",
                     ready_o, valid_o, busy_o, result_o, zero_flag_o, neg_flag_o);
        end
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_multiply();
        vec_t v[4];
        logic [31:0] res; logic zf, nf, ez, en; int lat;
        v[0] = '{OP_MUL,    32'hFFFF_FFFF, 32'd7,         32'hFFFF_FFF9, MUL_LAT, "mul_m1x7"};
        v[1] = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "mulhu_max"};
        v[2] = '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, "mulh_m1xm1"};
        v[3] = '{OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, MUL_LAT, "mulhsu_m1x2"};
        foreach (v[i]) begin
            issue(v[i].op, v[i].a, v[i].b, res, zf, nf, lat);
            ez = (v[i].exp == 32'h0); en = v[i].exp[31];
            checks++;
            if (res !== v[i].exp) begin
                errors++; $display("FAIL %s result: got %h, required %h", v[i].name, res, v[i].exp);
            end
            checks++;
            if (lat !== v[i].lat) begin
                errors++; $display("FAIL %s latency: got %0d, required %0d", v[i].name, lat, v[i].lat);
            end
            checks++;
            if (zf !== ez || nf !== en) begin
                errors++; $display("FAIL %s flags: got z=%b n=%b, required z=%b n=%b", v[i].name, zf, nf, ez, en);
            end
        end
    endtask

    task automatic test_divide();
        vec_t v[4];
        logic [31:0] res; logic zf, nf, ez, en; int lat;
        v[0] = '{OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT, "div_m7_2"};
        v[1] = '{OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT, "rem_m7_2"};
        v[2] = '{OP_DIVU, 32'd100,       32'd7, 32'd14,        DIV_LAT, "divu_100_7"};
        v[3] = '{OP_REMU, 32'd100,       32'd7, 32'd2,         DIV_LAT, "remu_100_7"};
        foreach (v[i]) begin
            issue(v[i].op, v[i].a, v[i].b, res, zf, nf, lat);
            ez = (v[i].exp == 32'h0); en = v[i].exp[31];
            checks++;
            if (res !== v[i].exp) begin
                errors++; $display("FAIL %s result: got %h, required %h", v[i].name, res, v[i].exp);
            end
            checks++;
            if (lat !== v[i].lat) begin
                errors++; $display("FAIL %s latency: got %0d, required %0d", v[i].name, lat, v[i].lat);
            end
            checks++;
            if (zf !== ez || nf !== en) begin
                errors++; $display("FAIL %s flags: got z=%b n=%b, required z=%b n=%b", v[i].name, zf, nf, ez, en);
            end
        end
    endtask

    task automatic test_special_cases();
        vec_t v[5];
        logic [31:0] res; logic zf, nf, ez, en; int lat;
        v[0] = '{OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1, "div_by0"};
        v[1] = '{OP_REM,  32'd5,         32'd0,         32'd5,         1, "rem_by0"};
        v[2] = '{OP_DIVU, 32'd9,         32'd0,         32'hFFFF_FFFF, 1, "divu_by0"};
        v[3] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf"};
        v[4] = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "rem_ovf"};
        foreach (v[i]) begin
            issue(v[i].op, v[i].a, v[i].b, res, zf, nf, lat);
            ez = (v[i].exp == 32'h0); en = v[i].exp[31];
            checks++;
            if (res !== v[i].exp) begin
                errors++; $display("FAIL %s result: got %h, required %h", v[i].name, res, v[i].exp);
            end
            checks++;
            if (lat !== v[i].lat) begin
                errors++; $display("FAIL %s latency: got %0d, required %0d", v[i].name, lat, v[i].lat);
            end
            checks++;
            if (zf !== ez || nf !== en) begin
                errors++; $display("FAIL %s flags: got z=%b n=%b, required z=%b n=%b", v[i].name, zf, nf, ez, en);
            end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        wait_ready();
        op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7; valid_i = 1'b1; ready_i = 1'b0;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        while (valid_o !== 1'b1 && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (valid_o !== 1'b1 || result_o !== 32'd14 || ready_o !== 1'b0 ||
                zero_flag_o !== 1'b0 || neg_flag_o !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: vld=%b res=%h rdy=%b z=%b n=%b, required 1 0000000e 0 0 0",
                         i, valid_o, result_o, ready_o, zero_flag_o, neg_flag_o);
            end
            @(posedge clk_i); #1;
        end
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++; $display("FAIL handshake_idle: rdy=%b vld=%b, required 1 0", ready_o, valid_o);
        end
        // Next request goes in on the very next edge
        op_i = OP_DIV; a_i = 32'd5; b_i = 32'd0; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || result_o !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL next_accept: vld=%b res=%h, required 1 ffffffff", valid_o, result_o);
        end
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n = 0;
        logic seen_idle = 1'b0;
        wait_ready();
        op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7; valid_i = 1'b1; ready_i = 1'b1;
        @(posedge clk_i); #1;
        // Count edges until the second request is accepted
        while (n < 100 && !(seen_idle && ready_o === 1'b0)) begin
            if (ready_o === 1'b1) seen_idle = 1'b1;
            @(posedge clk_i); #1;
            n++;
        end
        valid_i = 1'b0;
        checks++;
        if (n !== DIV_LAT + 1) begin
            errors++; $display("FAIL issue_interval: got %0d, required %0d", n, DIV_LAT + 1);
        end
        n = 0;
        while (valid_o !== 1'b1 && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        @(posedge clk_i); #1;
        ready_i = 1'b0;
    endtask

    task automatic test_flush();
        logic seen = 1'b0;
        wait_ready();
        op_i = OP_DIVU; a_i = 32'd1000; b_i = 32'd3; valid_i = 1'b1; ready_i = 1'b0;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        flush_i = 1'b1; valid_i = 1'b1; op_i = OP_DIV; a_i = 32'd5; b_i = 32'd0;
        @(posedge clk_i); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++; $display("FAIL flush_idle: rdy=%b busy=%b vld=%b, required 1 0 0", ready_o, busy_o, valid_o);
        end
        repeat (40) begin
            @(posedge clk_i); #1;
            if (valid_o === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL flush_no_result: valid_o seen=%b, required 0", seen);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] res; logic zf, nf; int lat;
        issue(OP_DIVU, 32'd100, 32'd7, res, zf, nf, lat);
        wait_ready();
        op_i = OP_DIVU; a_i = 32'd1000; b_i = 32'd3; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #2;
        reset_n_i = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_mid_ctrl: rdy=%b vld=%b busy=%b, required 1 0 0", ready_o, valid_o, busy_o);
        end
        checks++;
        if (result_o !== 32'h0 || zero_flag_o !== 1'b1 || neg_flag_o !== 1'b0) begin
            errors++; $display("FAIL reset_mid_data: res=%h z=%b n=%b, required 00000000 1 0", result_o, zero_flag_o, neg_flag_o);
        end
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_release: rdy=%b busy=%b, required 1 0", ready_o, busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_special_cases();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit executing the RV32M operation set for the pipelined CPU's execute stage. It sits beside the combinational ALU and takes multi-cycle operations from the execute stage through a valid/ready handshake. It returns a registered result with ALU-style zero/negative flags. A flush input supports branch-mispredict and trap squashing.

## Interface
- WIDTH, 32: operand and result width in bits; must be even and at least 8.
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request; high only in IDLE.
- op_i  in  3  operation code: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (encodings 0-7, in funct3 order).
- a_i  in  WIDTH  operand A (rs1).
- b_i  in  WIDTH  operand B (rs2).
- flush_i  in  1  abort any in-flight operation.
- valid_o  out  1  result valid; held until accepted.
- ready_i  in  1  consumer accepts the result.
- result_o  out  WIDTH  result.
- zero_flag_o  out  1  result_o == 0.
- neg_flag_o  out  1  result_o[WIDTH-1].
- busy_o  out  1  state is CALC.

## Operation
- Reset values: state IDLE, ready_o=1, valid_o=0, busy_o=0, result_o=0, zero_flag_o=1, neg_flag_o=0.
- States:
  - IDLE: on valid_i && ready_o, latch op_i, a_i, b_i and the operand signs, then move to CALC. Special cases go straight to DONE.
  - CALC: one iteration per cycle, counting down from WIDTH-1. After the last iteration, move to DONE.
  - DONE: valid_o=1. On ready_i, move to IDLE.
- Signed operations (MUL/MULH/DIV/REM signed operands, MULHSU A only): iterate on operand magnitudes. Apply the sign fix in the final CALC cycle.
  - Product is negated if the signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
- Multiply uses shift-add on a 2*WIDTH accumulator. MUL returns the low half. MULH, MULHSU and MULHU return the high half.
- Divide uses restoring radix-2, one quotient bit per cycle.
- Special cases, resolved in IDLE with no CALC:
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return a_i.
  - Signed overflow (a_i = most-negative value, b_i = all ones): DIV returns a_i; REM returns 0.
- Flags are computed from the registered result_o and are valid whenever valid_o is high.
- flush_i has priority over every other input. From any state, the next state is IDLE and valid_o is 0; the result is discarded. A request presented in the same cycle as flush_i is not accepted.

## Timing
- Accept edge = cycle 0.
- Normal operations: valid_o rises at cycle WIDTH+1, which is cycle 33 for WIDTH=32.
- Special cases: valid_o rises at cycle 1.
- Back-to-back: IDLE is re-entered the cycle after the ready_i handshake, so the minimum issue interval is latency+1 cycles.
- valid_o, result_o and flags stay stable while valid_o && !ready_i.
- Reset asserted mid-operation returns all outputs to their reset values immediately, asynchronously.

## Configuration
- MULDIV_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU use a single-cycle full-width multiplier and go IDLE→DONE with latency 1. Divide operations are unchanged.
- Not defined: all multiplies are iterative with latency WIDTH+1.

## Structure
- muldiv_pkg holds:
  - muldiv_op_e, the op enum.
  - muldiv_state_e: IDLE, CALC, DONE.
  - helper functions is_div(op), is_signed_a(op), is_signed_b(op).
- One sub-module, muldiv_iter_core: the shared accumulator/shift datapath performing one multiply or divide step per enable. The FSM, special-case detection and sign fix remain in muldiv_unit.

## Test plan
- MUL a=0xFFFF_FFFF (−1), b=7 → result 0xFFFF_FFF9, neg=1, valid_o at cycle 33 (cycle 1 with MULDIV_FAST_MUL_EN).
- MULHU a=b=0xFFFF_FFFF → 0xFFFF_FFFE. MULH on the same operands → 0. MULHSU a=0xFFFF_FFFF, b=2 → 0xFFFF_FFFF.
- DIV a=−7, b=2 → −3 (0xFFFF_FFFD). REM on the same operands → −1. DIVU a=100, b=7 → 14. REMU on the same operands → 2.
- DIV a=5, b=0 → 0xFFFF_FFFF, valid_o at cycle 1. REM a=5, b=0 → 5. DIV a=0x8000_0000, b=−1 → 0x8000_0000. REM on the same operands → 0, zero=1.
- Backpressure: hold ready_i=0 for 10 cycles after valid_o rises → result_o stable and ready_o=0 throughout. The next request is accepted the cycle after the handshake.
- Flush at CALC cycle 10, with a new valid_i in the same cycle → no valid_o, request not accepted, ready_o=1 next cycle. A reset_n_i pulse mid-CALC → all outputs at their reset values.
